// File: rtl/codec_pkg.sv
// Shared frame geometry and helpers for the I2S codec interface.
// Pure constants and combinational functions; no latency, no flow control.
package codec_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int SLOT_BITS = 32;
    localparam int FRAME_DIV = 512;
    localparam int BCLK_DIV  = 8;

    localparam int CNT_W    = $clog2(FRAME_DIV);
    localparam int SLOT_W   = $clog2(SLOT_BITS);
    localparam int SLOT_LSB = $clog2(BCLK_DIV);
    localparam int BCLK_BIT = SLOT_LSB - 1;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [SLOT_W-1:0]   slot_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    // One-BCLK I2S delay: slot 0 is idle, slots 1..24 carry bits 23..0.
    function automatic logic is_data_slot(slot_t s);
        return (s != '0) && (int'(s) <= SAMPLE_W);
    endfunction

    function automatic logic slot_bit(sample_t w, slot_t s);
        slot_t idx;
        idx = slot_t'(SAMPLE_W - int'(s));
        if (!is_data_slot(s)) return 1'b0;
        return w[idx];
    endfunction

endpackage

// File: rtl/codec_clkgen.sv
// Free-running frame counter producing registered MCLK/BCLK/LRCK plus next-edge slot info and strobes.
// Clock outputs track the counter with zero skew; strobes describe the coming edge; no backpressure.
module codec_clkgen
    import codec_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    output logic  mclk,
    output logic  bclk,
    output logic  lrck,
    output slot_t slot_nxt,
    output logic  right_nxt,
    output logic  bclk_fall_stb,
    output logic  bclk_rise_stb,
    output logic  left_done_stb,
    output logic  frame_wrap_stb
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mclk_q, mclk_d;
    logic             bclk_q, bclk_d;
    logic             lrck_q, lrck_d;

    // Clock flops load from the next count so they equal the live count bits without decode glitches.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        mclk_d = cnt_d[0];
        bclk_d = cnt_d[BCLK_BIT];
        lrck_d = cnt_d[CNT_W-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            mclk_q <= 1'b0;
            bclk_q <= 1'b0;
            lrck_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mclk_q <= mclk_d;
            bclk_q <= bclk_d;
            lrck_q <= lrck_d;
        end
    end

    assign mclk           = mclk_q;
    assign bclk           = bclk_q;
    assign lrck           = lrck_q;
    assign slot_nxt       = cnt_d[SLOT_LSB +: SLOT_W];
    assign right_nxt      = cnt_d[CNT_W-1];
    assign bclk_fall_stb  = (cnt_d[SLOT_LSB-1:0] == '0);
    assign bclk_rise_stb  = (cnt_d[SLOT_LSB-1:0] == SLOT_LSB'(BCLK_DIV / 2));
    assign left_done_stb  = (cnt_q == CNT_W'(FRAME_DIV / 2 - 1));
    assign frame_wrap_stb = (cnt_q == CNT_W'(FRAME_DIV - 1));

endmodule

// File: rtl/codec.sv
// I2S master for an external 24-bit stereo codec: DAC serializer, ADC deserializer, power-up timer.
// DAC pair latched per frame, ADC pair presented per frame with a one-clk strobe; no backpressure.
module codec
    import codec_pkg::*;
#(
    parameter int unsigned PDN_DELAY = 1024
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] LCH_DAC,
    input  logic [SAMPLE_W-1:0] RCH_DAC,
    input  logic                SDTI,
    output logic [SAMPLE_W-1:0] LCH_ADC,
    output logic [SAMPLE_W-1:0] RCH_ADC,
    output logic                ADC_VALID,
    output logic                PDN,
    output logic                MCLK,
    output logic                BCLK,
    output logic                LRCK,
    output logic                SDTO
);

    localparam int PW = $clog2(PDN_DELAY + 1);

    slot_t   slot_nxt;
    logic    right_nxt, bclk_fall_stb, bclk_rise_stb, left_done_stb, frame_wrap_stb;

    stereo_t dac_lat_q, dac_lat_d;
    sample_t adc_sreg_q, adc_sreg_d;
    sample_t lch_adc_q, lch_adc_d;
    sample_t rch_adc_q, rch_adc_d;
    logic    adc_valid_q, adc_valid_d;
    logic    sdto_q, sdto_d;
    logic    pdn_q, pdn_d;
    logic [PW-1:0] pdn_cnt_q, pdn_cnt_d;

    codec_clkgen u_clkgen (
        .clk            (clk),
        .rst            (rst),
        .mclk           (MCLK),
        .bclk           (BCLK),
        .lrck           (LRCK),
        .slot_nxt       (slot_nxt),
        .right_nxt      (right_nxt),
        .bclk_fall_stb  (bclk_fall_stb),
        .bclk_rise_stb  (bclk_rise_stb),
        .left_done_stb  (left_done_stb),
        .frame_wrap_stb (frame_wrap_stb)
    );

    always_comb begin
        dac_lat_d   = dac_lat_q;
        adc_sreg_d  = adc_sreg_q;
        lch_adc_d   = lch_adc_q;
        rch_adc_d   = rch_adc_q;
        sdto_d      = sdto_q;
        pdn_d       = pdn_q;
        pdn_cnt_d   = pdn_cnt_q;
        adc_valid_d = frame_wrap_stb;

        // Slot 0 of the new frame is idle, so the old latch can still drive SDTO on the wrap edge.
        if (frame_wrap_stb) begin
            dac_lat_d.l = LCH_DAC;
            dac_lat_d.r = RCH_DAC;
            rch_adc_d   = adc_sreg_q;
        end
        if (left_done_stb) begin
            lch_adc_d = adc_sreg_q;
        end
        if (bclk_fall_stb) begin
            sdto_d = slot_bit(right_nxt ? dac_lat_q.r : dac_lat_q.l, slot_nxt);
        end
        if (bclk_rise_stb && is_data_slot(slot_nxt)) begin
            adc_sreg_d = {adc_sreg_q[SAMPLE_W-2:0], SDTI};
        end
        if (!pdn_q) begin
            pdn_cnt_d = pdn_cnt_q + 1'b1;
            pdn_d     = (pdn_cnt_q == PW'(PDN_DELAY - 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_lat_q   <= '0;
            adc_sreg_q  <= '0;
            lch_adc_q   <= '0;
            rch_adc_q   <= '0;
            adc_valid_q <= 1'b0;
            sdto_q      <= 1'b0;
            pdn_q       <= 1'b0;
            pdn_cnt_q   <= '0;
        end else begin
            dac_lat_q   <= dac_lat_d;
            adc_sreg_q  <= adc_sreg_d;
            lch_adc_q   <= lch_adc_d;
            rch_adc_q   <= rch_adc_d;
            adc_valid_q <= adc_valid_d;
            sdto_q      <= sdto_d;
            pdn_q       <= pdn_d;
            pdn_cnt_q   <= pdn_cnt_d;
        end
    end

    assign LCH_ADC   = lch_adc_q;
    assign RCH_ADC   = rch_adc_q;
    assign ADC_VALID = adc_valid_q;
    assign PDN       = pdn_q;
    assign SDTO      = sdto_q;

endmodule

// File: tb/tb_codec.sv
// Self-checking bench for codec: frame-position reference model plus directed and random scenarios.
module tb_codec;

    localparam int PDN_DELAY = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] LCH_DAC = '0;
    logic [23:0] RCH_DAC = '0;
    logic        loop_en = 1'b0;
    logic        sdti_rand = 1'b0;
    logic        SDTI;
    logic [23:0] LCH_ADC, RCH_ADC;
    logic        ADC_VALID, PDN, MCLK, BCLK, LRCK, SDTO;

    int tests_run = 0;
    int tests_failed = 0;

    assign SDTI = loop_en ? SDTO : sdti_rand;

    codec #(.PDN_DELAY(PDN_DELAY)) dut (
        .clk       (clk),
        .rst       (rst),
        .LCH_DAC   (LCH_DAC),
        .RCH_DAC   (RCH_DAC),
        .SDTI      (SDTI),
        .LCH_ADC   (LCH_ADC),
        .RCH_ADC   (RCH_ADC),
        .ADC_VALID (ADC_VALID),
        .PDN       (PDN),
        .MCLK      (MCLK),
        .BCLK      (BCLK),
        .LRCK      (LRCK),
        .SDTO      (SDTO)
    );

    always #5 clk = ~clk;

    // Reference model: n = rising edges since reset release; everything follows from frame position.
    int          n = 0;
    logic [23:0] m_lw = '0, m_rw = '0, m_acc = '0, m_ladc = '0, m_radc = '0;
    logic        m_valid = 1'b0;

    function automatic int slot_of(int k);
        return (k % 256) / 8;
    endfunction

    function automatic bit data_slot(int k);
        return slot_of(k) >= 1 && slot_of(k) <= 24;
    endfunction

    function automatic logic exp_sdto(int k);
        logic [23:0] w;
        if (!data_slot(k)) return 1'b0;
        w = ((k % 512) >= 256) ? m_rw : m_lw;
        return w[24 - slot_of(k)];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            n <= 0; m_lw <= '0; m_rw <= '0; m_acc <= '0;
            m_ladc <= '0; m_radc <= '0; m_valid <= 1'b0;
        end else begin
            n       <= n + 1;
            m_valid <= ((n + 1) % 512 == 0);
            if ((n + 1) % 512 == 0) begin
                m_lw <= LCH_DAC; m_rw <= RCH_DAC; m_radc <= m_acc;
            end
            if ((n + 1) % 512 == 256) m_ladc <= m_acc;
            if ((n + 1) % 8 == 4 && data_slot(n + 1)) m_acc[24 - slot_of(n + 1)] <= SDTI;
        end
    end

    task automatic wait_pos(input int pos, output bit ok);
        int g = 0;
        while (n % 512 != pos && g < 1100) begin
            @(negedge clk);
            g++;
        end
        ok = (n % 512 == pos);
    endtask

    task automatic test_reset();
        rst = 1'b0; LCH_DAC = '1; RCH_DAC = '1; loop_en = 1'b0;
        repeat (25) begin
            @(negedge clk);
            tests_run++;
            if ({LCH_ADC, RCH_ADC, ADC_VALID, PDN, MCLK, BCLK, LRCK, SDTO} !== 54'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got %h, expected 0",
                         {LCH_ADC, RCH_ADC, ADC_VALID, PDN, MCLK, BCLK, LRCK, SDTO});
            end
        end
    endtask

    // Release with all-ones DAC: clocks, PDN timing, zero first frame, all-ones second frame.
    task automatic test_startup();
        int ones1 = 0, ones2 = 0, first_pdn = -1;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            tests_run++;
            if ({MCLK, BCLK, LRCK} !== {n[0], n[2], n[8]}) begin
                tests_failed++;
                $display("FAIL clk_div n=%0d: got %b, expected %b", n, {MCLK, BCLK, LRCK}, {n[0], n[2], n[8]});
            end
            tests_run++;
            if (PDN !== (n >= PDN_DELAY)) begin
                tests_failed++;
                $display("FAIL pdn_level n=%0d: got %b, expected %b", n, PDN, n >= PDN_DELAY);
            end
            tests_run++;
            if (SDTO !== exp_sdto(n)) begin
                tests_failed++;
                $display("FAIL startup_sdto n=%0d: got %b, expected %b", n, SDTO, exp_sdto(n));
            end
            if (n % 8 == 4 && SDTO === 1'b1) begin
                if (n < 512) ones1++;
                else if (n < 1024) ones2++;
            end
            if (PDN === 1'b1 && first_pdn < 0) first_pdn = n;
        end
        tests_run++;
        if (ones1 != 0) begin tests_failed++; $display("FAIL first_frame_zero: got %0d ones, expected 0", ones1); end
        tests_run++;
        if (ones2 != 48) begin tests_failed++; $display("FAIL second_frame_ones: got %0d ones, expected 48", ones2); end
        tests_run++;
        if (first_pdn != PDN_DELAY) begin tests_failed++; $display("FAIL pdn_rise: got %0d, expected %0d", first_pdn, PDN_DELAY); end
    endtask

    task automatic test_midframe();
        bit ok;
        int fs;
        logic [23:0] dec_l = '0, dec_r = '0, nxt_or = '0;
        wait_pos(500, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL midframe_align: got pos %0d, expected 500", n % 512); end
        LCH_DAC = 24'hA5A5A5; RCH_DAC = 24'h123456;
        fs = n / 512 + 1;
        for (int g = 0; g < 1200 && n < 512 * (fs + 2); g++) begin
            @(negedge clk);
            if (n / 512 == fs && n % 512 == 100) begin LCH_DAC = '0; RCH_DAC = '0; end
            tests_run++;
            if (SDTO !== exp_sdto(n)) begin
                tests_failed++;
                $display("FAIL midframe_sdto n=%0d: got %b, expected %b", n, SDTO, exp_sdto(n));
            end
            if (n % 8 == 4 && data_slot(n)) begin
                if (n / 512 == fs && n % 512 < 256) dec_l = {dec_l[22:0], SDTO};
                else if (n / 512 == fs) dec_r = {dec_r[22:0], SDTO};
                else if (n / 512 == fs + 1) nxt_or = {nxt_or[22:0], SDTO};
            end
        end
        tests_run++;
        if (dec_l !== 24'hA5A5A5) begin tests_failed++; $display("FAIL midframe_left: got %h, expected a5a5a5", dec_l); end
        tests_run++;
        if (dec_r !== 24'h123456) begin tests_failed++; $display("FAIL midframe_right: got %h, expected 123456", dec_r); end
        tests_run++;
        if (nxt_or !== 24'h0) begin tests_failed++; $display("FAIL next_frame_zero: got %h, expected 0", nxt_or); end
    endtask

    task automatic test_loopback();
        bit ok;
        int fs, vcnt = 0, vbad = 0;
        loop_en = 1'b1;
        wait_pos(500, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL loop_align: got pos %0d, expected 500", n % 512); end
        LCH_DAC = 24'h800001; RCH_DAC = 24'h7FFFFE;
        fs = n / 512 + 1;
        for (int g = 0; g < 1200 && n < 512 * (fs + 2) + 4; g++) begin
            @(negedge clk);
            tests_run++;
            if ({LCH_ADC, RCH_ADC, ADC_VALID} !== {m_ladc, m_radc, m_valid}) begin
                tests_failed++;
                $display("FAIL loop_adc n=%0d: got %h/%h/%b, expected %h/%h/%b",
                         n, LCH_ADC, RCH_ADC, ADC_VALID, m_ladc, m_radc, m_valid);
            end
            if (ADC_VALID === 1'b1) begin
                vcnt++;
                if (n % 512 != 0) vbad++;
            end
        end
        loop_en = 1'b0;
        tests_run++;
        if (LCH_ADC !== 24'h800001) begin tests_failed++; $display("FAIL loop_lch: got %h, expected 800001", LCH_ADC); end
        tests_run++;
        if (RCH_ADC !== 24'h7FFFFE) begin tests_failed++; $display("FAIL loop_rch: got %h, expected 7ffffe", RCH_ADC); end
        tests_run++;
        if (vcnt != 3 || vbad != 0) begin
            tests_failed++;
            $display("FAIL adc_valid_pulses: got %0d (misplaced %0d), expected 3 (misplaced 0)", vcnt, vbad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3 * 512; i++) begin
            @(negedge clk);
            tests_run++;
            if ({SDTO, LCH_ADC, RCH_ADC, ADC_VALID} !== {exp_sdto(n), m_ladc, m_radc, m_valid}) begin
                tests_failed++;
                $display("FAIL random n=%0d: got %b/%h/%h/%b, expected %b/%h/%h/%b", n, SDTO, LCH_ADC,
                         RCH_ADC, ADC_VALID, exp_sdto(n), m_ladc, m_radc, m_valid);
            end
            sdti_rand = 1'($urandom);
            if ($urandom_range(0, 63) == 0) begin
                LCH_DAC = 24'($urandom);
                RCH_DAC = 24'($urandom);
            end
        end
    endtask

    task automatic test_async_reset();
        int first_pdn = -1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (600) @(negedge clk);
        tests_run++;
        if (PDN !== 1'b0 || n != 600) begin tests_failed++; $display("FAIL pdn_before_pulse: got %b at n=%0d, expected 0 at 600", PDN, n); end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({LCH_ADC, RCH_ADC, ADC_VALID, PDN, MCLK, BCLK, LRCK, SDTO} !== 54'd0) begin
            tests_failed++;
            $display("FAIL async_clear: got %h, expected 0",
                     {LCH_ADC, RCH_ADC, ADC_VALID, PDN, MCLK, BCLK, LRCK, SDTO});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            @(negedge clk);
            tests_run++;
            if ({MCLK, BCLK, LRCK, PDN} !== {n[0], n[2], n[8], 1'(n >= PDN_DELAY)}) begin
                tests_failed++;
                $display("FAIL restart n=%0d: got %b, expected %b", n, {MCLK, BCLK, LRCK, PDN},
                         {n[0], n[2], n[8], 1'(n >= PDN_DELAY)});
            end
            if (PDN === 1'b1 && first_pdn < 0) first_pdn = n;
        end
        tests_run++;
        if (first_pdn != PDN_DELAY) begin tests_failed++; $display("FAIL pdn_restart_rise: got %0d, expected %0d", first_pdn, PDN_DELAY); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_midframe();
        test_loopback();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
